// File: rtl/jr_scoreboard_pkg.sv
// Shared pipeline definitions for the jr scoreboard: forwarding encoding,
// shadow-pipeline entry type, stall FSM states and an entry constructor.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WR  = 2'b11;

  // Register address width carried by a shadow entry; must equal REG_AW.
  localparam int SB_AW = 5;

  typedef struct packed {
    logic             v;
    logic [SB_AW-1:0] rw;
    logic             wr_en;
    logic             ld;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    LDW2 = 2'b01,
    LDW1 = 2'b10
  } jr_state_t;

  // Builds a valid entry; writes to r0 are dropped so r0 never matches.
  function automatic sb_entry_t make_entry(input logic [SB_AW-1:0] rw,
                                           input logic reg_wr,
                                           input logic load);
    sb_entry_t e;
    e.v     = 1'b1;
    e.rw    = rw;
    e.wr_en = reg_wr && (rw != '0);
    e.ld    = load;
    return e;
  endfunction

endpackage

// File: rtl/jr_scoreboard_if.sv
// ID-stage <-> jr scoreboard bundle. master = ID/hazard side, slave = scoreboard.
interface jr_scoreboard_if #(
  parameter int REG_AW   = 5,
  parameter int STALL_CW = 16
);
  logic                id_valid;
  logic                id_is_jr;
  logic [REG_AW-1:0]   id_rs;
  logic                issue;
  logic [REG_AW-1:0]   issue_rw;
  logic                issue_regWr;
  logic                issue_load;
  logic                flush;
  logic [1:0]          fwd_sel;
  logic                stall;
  logic [STALL_CW-1:0] stall_cnt;

  modport master (
    output id_valid, id_is_jr, id_rs, issue, issue_rw, issue_regWr, issue_load, flush,
    input  fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_is_jr, id_rs, issue, issue_rw, issue_regWr, issue_load, flush,
    output fwd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/jr_scoreboard_match.sv
// sb_match: compares one shadow entry against the jr source register.
module sb_match
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  sb_entry_t         entry,
  input  logic [REG_AW-1:0] rs,
  output logic              hit,
  output logic              hit_load
);

  assign hit      = entry.v && entry.wr_en && (entry.rw == rs);
  assign hit_load = hit && entry.ld;

endmodule

// File: rtl/jr_scoreboard.sv
// jr_scoreboard: EX/MEM/WR shadow of issued destinations. Selects the
// forwarding source for the ID-stage jr operand and stalls ID on a pending load.
// Optional stall statistics counter: define JR_SCOREBOARD_STATS_EN.
module jr_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int STALL_CW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  jr_scoreboard_if.slave sb
);

  sb_entry_t ex_q, mem_q, wr_q;
  jr_state_t state_q;

  logic ex_hit, ex_ld, mem_hit, mem_ld, wr_hit, wr_ld_unused;
  logic jr_active, ex_hazard, mem_hazard, new_hazard, stall_int;
  logic [1:0] fwd_sel_int;

  sb_match #(.REG_AW(REG_AW)) u_match_ex (
    .entry(ex_q), .rs(sb.id_rs), .hit(ex_hit), .hit_load(ex_ld)
  );
  sb_match #(.REG_AW(REG_AW)) u_match_mem (
    .entry(mem_q), .rs(sb.id_rs), .hit(mem_hit), .hit_load(mem_ld)
  );
  sb_match #(.REG_AW(REG_AW)) u_match_wr (
    .entry(wr_q), .rs(sb.id_rs), .hit(wr_hit), .hit_load(wr_ld_unused)
  );

  // Newest producer wins for the operand select; load hazards only matter for a jr in ID.
  always_comb begin
    jr_active  = sb.id_valid && sb.id_is_jr;
    ex_hazard  = jr_active && ex_ld;
    mem_hazard = jr_active && !ex_hit && mem_ld;
    new_hazard = ex_hazard || mem_hazard;
    stall_int  = new_hazard || (state_q == LDW2);
    if (ex_hit)       fwd_sel_int = FWD_EX;
    else if (mem_hit) fwd_sel_int = FWD_MEM;
    else if (wr_hit)  fwd_sel_int = FWD_WR;
    else              fwd_sel_int = FWD_RF;
  end

  assign sb.fwd_sel = fwd_sel_int;
  assign sb.stall   = stall_int;

  // Shadow pipeline: shift every clock, bubble into EX on stall, flush or no issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wr_q  <= '0;
    end else begin
      mem_q <= ex_q;
      wr_q  <= mem_q;
      if (sb.issue && !stall_int && !sb.flush)
        ex_q <= make_entry(sb.issue_rw, sb.issue_regWr, sb.issue_load);
      else
        ex_q <= '0;
    end
  end

  // Load-wait tracker: LDW2 holds the second stall cycle of an EX load hazard;
  // a flush abandons the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (!sb.flush) begin
            if (ex_hazard)       state_q <= LDW2;
            else if (mem_hazard) state_q <= LDW1;
          end
        end
        LDW2:    state_q <= sb.flush ? RUN : LDW1;
        LDW1:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef JR_SCOREBOARD_STATS_EN
  logic [STALL_CW-1:0] stall_cnt_q;

  // Saturating count of cycles spent stalled on a jr operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (stall_int && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + STALL_CW'(1);
  end

  assign sb.stall_cnt = stall_cnt_q;
`else
  assign sb.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_jr_scoreboard.sv
// Directed testbench for jr_scoreboard; expected values are hand-computed.
// Stall counter expectations follow JR_SCOREBOARD_STATS_EN.
module tb_jr_scoreboard;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  jr_scoreboard_if #(.REG_AW(5), .STALL_CW(16)) sb_bus ();

  jr_scoreboard #(.REG_AW(5), .STALL_CW(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sb   (sb_bus)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic checkPair(input string tag, input logic [1:0] exp_fwd, input logic exp_stall);
    checkOutput({tag, "_fwd"}, 32'(sb_bus.fwd_sel), 32'(exp_fwd));
    checkOutput({tag, "_stall"}, 32'(sb_bus.stall), 32'(exp_stall));
  endtask

  // Drives one ID cycle shortly after the rising edge, then lets comb settle.
  task automatic applyStimulus(input logic valid, input logic is_jr, input logic [4:0] rs,
                               input logic iss, input logic [4:0] rw, input logic reg_wr,
                               input logic load, input logic fl);
    @(posedge clk);
    #1;
    sb_bus.id_valid    = valid;
    sb_bus.id_is_jr    = is_jr;
    sb_bus.id_rs       = rs;
    sb_bus.issue       = iss;
    sb_bus.issue_rw    = rw;
    sb_bus.issue_regWr = reg_wr;
    sb_bus.issue_load  = load;
    sb_bus.flush       = fl;
    #1;
  endtask

  task automatic drainPipe();
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
  endtask

  logic [15:0] exp_cnt2;

  initial begin
    checks = 0;
    errors = 0;
`ifdef JR_SCOREBOARD_STATS_EN
    exp_cnt2 = 16'd2;
`else
    exp_cnt2 = 16'd0;
`endif
    rst_n              = 1'b0;
    sb_bus.id_valid    = 1'b0;
    sb_bus.id_is_jr    = 1'b0;
    sb_bus.id_rs       = '0;
    sb_bus.issue       = 1'b0;
    sb_bus.issue_rw    = '0;
    sb_bus.issue_regWr = 1'b0;
    sb_bus.issue_load  = 1'b0;
    sb_bus.flush       = 1'b0;

    #3;
    checkPair("reset", 2'b00, 1'b0);
    checkOutput("reset_cnt", 32'(sb_bus.stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted during the second stall cycle of a load hazard
    applyStimulus(1, 0, 5'd0, 1, 5'd8, 1, 1, 0);
    applyStimulus(1, 1, 5'd8, 0, 5'd0, 0, 0, 0);
    checkPair("rstmid_s1", 2'b01, 1'b1);
    applyStimulus(1, 1, 5'd8, 0, 5'd0, 0, 0, 0);
    checkPair("rstmid_s2", 2'b10, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkPair("rstmid_after", 2'b00, 1'b0);
    checkOutput("rstmid_cnt", 32'(sb_bus.stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drainPipe();

    // lw r8 then dependent jr: two stall cycles, issue held during stall is ignored
    applyStimulus(1, 0, 5'd0, 1, 5'd8, 1, 1, 0);
    applyStimulus(1, 1, 5'd8, 1, 5'd8, 1, 0, 0);
    checkPair("ldjr_s1", 2'b01, 1'b1);
    applyStimulus(1, 1, 5'd8, 0, 5'd0, 0, 0, 0);
    checkPair("ldjr_s2", 2'b10, 1'b1);
    applyStimulus(1, 1, 5'd8, 0, 5'd0, 0, 0, 0);
    checkPair("ldjr_rel", 2'b11, 1'b0);
    checkOutput("ldjr_cnt", 32'(sb_bus.stall_cnt), 32'(exp_cnt2));
    drainPipe();

    // add r5 walks EX -> MEM -> WR -> gone
    applyStimulus(1, 0, 5'd0, 1, 5'd5, 1, 0, 0);
    applyStimulus(1, 1, 5'd5, 0, 5'd0, 0, 0, 0);
    checkPair("add_ex", 2'b01, 1'b0);
    applyStimulus(1, 1, 5'd5, 0, 5'd0, 0, 0, 0);
    checkPair("add_mem", 2'b10, 1'b0);
    applyStimulus(1, 1, 5'd5, 0, 5'd0, 0, 0, 0);
    checkPair("add_wr", 2'b11, 1'b0);
    applyStimulus(1, 1, 5'd5, 0, 5'd0, 0, 0, 0);
    checkPair("add_gone", 2'b00, 1'b0);
    drainPipe();

    // lw r8, unrelated add r3, then jr r8: one stall cycle
    applyStimulus(1, 0, 5'd0, 1, 5'd8, 1, 1, 0);
    applyStimulus(1, 0, 5'd0, 1, 5'd3, 1, 0, 0);
    applyStimulus(1, 1, 5'd8, 0, 5'd0, 0, 0, 0);
    checkPair("ldgap_s1", 2'b10, 1'b1);
    applyStimulus(1, 1, 5'd8, 0, 5'd0, 0, 0, 0);
    checkPair("ldgap_rel", 2'b11, 1'b0);
    drainPipe();

    // Writes to r0 never match
    applyStimulus(1, 0, 5'd0, 1, 5'd0, 1, 0, 0);
    applyStimulus(1, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    checkPair("r0", 2'b00, 1'b0);
    drainPipe();

    // Same rw in EX and MEM: EX wins, then MEM over WR
    applyStimulus(1, 0, 5'd0, 1, 5'd7, 1, 0, 0);
    applyStimulus(1, 0, 5'd0, 1, 5'd7, 1, 0, 0);
    applyStimulus(1, 1, 5'd7, 0, 5'd0, 0, 0, 0);
    checkPair("coll_ex", 2'b01, 1'b0);
    applyStimulus(1, 1, 5'd7, 0, 5'd0, 0, 0, 0);
    checkPair("coll_mem", 2'b10, 1'b0);
    drainPipe();

    // lw r4 then jr r4 flushed in the first stall cycle
    applyStimulus(1, 0, 5'd0, 1, 5'd4, 1, 1, 0);
    applyStimulus(1, 1, 5'd4, 0, 5'd0, 0, 0, 1);
    checkPair("flush_s1", 2'b01, 1'b1);
    applyStimulus(0, 0, 5'd4, 0, 5'd0, 0, 0, 0);
    checkPair("flush_idle", 2'b10, 1'b0);
    applyStimulus(1, 1, 5'd9, 0, 5'd0, 0, 0, 0);
    checkPair("flush_other", 2'b00, 1'b0);
    drainPipe();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
